// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_if
// Purpose  : Instruction-memory request/acknowledge bus used by the fetch stage.
// Revision : 1.0
// ============================================================================
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : PC owner, instruction-memory requester and IF/ID pipeline register.
// Revision : 1.0
// ============================================================================
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP      = 16'h0000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        pc_enable,
  input  wire logic        halt,
  input  wire logic        branch_taken,
  input  wire logic [15:0] branch_target,
  fetch_stage_if.master    imem,
  output logic      [15:0] instruction_ID,
  output logic      [15:0] pc_ID,
  output logic             valid_ID
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_HOLD   = 3'd1,
    S_FLUSH  = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] redirect_pc_q, redirect_pc_d;
  logic [15:0] buf_instr_q, buf_instr_d;
  logic [15:0] buf_pc_q, buf_pc_d;
  logic [15:0] instr_id_q, instr_id_d;
  logic [15:0] pc_id_q, pc_id_d;
  logic        valid_id_q, valid_id_d;

  logic        ack;
  logic [15:0] rdata;

  assign ack   = imem.imem_ack;
  assign rdata = imem.imem_rdata;

  // A request stays up in FLUSH and DRAIN so the outstanding ack can still land.
  assign imem.imem_req  = !rst && ((state_q == S_FETCH) || (state_q == S_FLUSH) ||
                                   (state_q == S_DRAIN));
  assign imem.imem_addr = pc_q;

  assign instruction_ID = instr_id_q;
  assign pc_ID          = pc_id_q;
  assign valid_ID       = valid_id_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    instr_id_d    = instr_id_q;
    pc_id_d       = pc_id_q;
    valid_id_d    = valid_id_q;

    // Decode consuming with nothing new to hand over sees a bubble; a stall holds.
    if (pc_enable) begin
      instr_id_d = NOP;
      valid_id_d = 1'b0;
    end

    case (state_q)
      S_FETCH: begin
        if (branch_taken) begin
          instr_id_d = NOP;
          valid_id_d = 1'b0;
          if (ack) begin
            pc_d = branch_target;
          end else begin
            redirect_pc_d = branch_target;
            state_d       = S_FLUSH;
          end
        end else if (halt) begin
          state_d = ack ? S_HALTED : S_DRAIN;
        end else if (ack) begin
          pc_d = pc_q + 16'd2;
          if (pc_enable) begin
            instr_id_d = rdata;
            pc_id_d    = pc_q;
            valid_id_d = 1'b1;
          end else begin
            buf_instr_d = rdata;
            buf_pc_d    = pc_q;
            state_d     = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (branch_taken) begin
          instr_id_d = NOP;
          valid_id_d = 1'b0;
          pc_d       = branch_target;
          state_d    = S_FETCH;
        end else if (halt) begin
          state_d = S_HALTED;
        end else if (pc_enable) begin
          instr_id_d = buf_instr_q;
          pc_id_d    = buf_pc_q;
          valid_id_d = 1'b1;
          state_d    = S_FETCH;
        end
      end

      S_FLUSH: begin
        if (branch_taken) begin
          instr_id_d = NOP;
          valid_id_d = 1'b0;
          if (ack) begin
            pc_d    = branch_target;
            state_d = S_FETCH;
          end else begin
            redirect_pc_d = branch_target;
          end
        end else if (halt) begin
          // If the stale ack arrives together with halt nothing is left to drain.
          state_d = ack ? S_HALTED : S_DRAIN;
        end else if (ack) begin
          pc_d    = redirect_pc_q;
          state_d = S_FETCH;
        end
      end

      S_DRAIN: begin
        if (ack) begin
          state_d = S_HALTED;
        end
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      redirect_pc_q <= 16'h0000;
      buf_instr_q   <= 16'h0000;
      buf_pc_q      <= 16'h0000;
      instr_id_q    <= NOP;
      pc_id_q       <= 16'h0000;
      valid_id_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc_q      <= buf_pc_d;
      instr_id_q    <= instr_id_d;
      pc_id_q       <= pc_id_d;
      valid_id_q    <= valid_id_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage with a latency-programmable memory.
// Revision : 1.0
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_enable = 1'b0;
  logic        halt = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic [15:0] instruction_ID, pc_ID;
  logic        valid_ID;
  logic [15:0] instr2, pcid2;
  logic        valid2;

  int n_vec = 0;
  int n_err = 0;

  fetch_stage_if bus ();
  fetch_stage_if bus2 ();

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000), .NOP(16'h0000)) dut (
    .clk(clk), .rst(rst), .pc_enable(pc_enable), .halt(halt),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem(bus.master),
    .instruction_ID(instruction_ID), .pc_ID(pc_ID), .valid_ID(valid_ID)
  );

  fetch_stage #(.RESET_PC(16'hFFFE), .NOP(16'h0000)) dut_wrap (
    .clk(clk), .rst(rst), .pc_enable(1'b1), .halt(1'b0),
    .branch_taken(1'b0), .branch_target(16'h0000),
    .imem(bus2.master),
    .instruction_ID(instr2), .pc_ID(pcid2), .valid_ID(valid2)
  );

  // Memory: acks after lat wait cycles, returns addr+0x1000, forgets requests on reset.
  int unsigned lat = 0;
  int unsigned wait_cnt = 0;
  assign bus.imem_ack   = bus.imem_req && (wait_cnt >= lat);
  assign bus.imem_rdata = bus.imem_addr + 16'h1000;
  always_ff @(posedge clk) begin
    if (rst || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
    else                                       wait_cnt <= wait_cnt + 1;
  end
  assign bus2.imem_ack   = bus2.imem_req;
  assign bus2.imem_rdata = bus2.imem_addr + 16'h1000;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        pe;
    logic        br;
    logic        hlt;
    logic [15:0] tgt;
    int unsigned lat;
    logic        req;
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pcid;
    logic        valid;
  } vec_t;

  vec_t tbl[24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s_pe, s_br, s_ack, s_req, s_valid;
    logic [15:0] s_tgt, s_addr, s_instr, s_pcid, exp_next;
    int          loads;

    //           rst pe br hl tgt       lat | req addr      instr     pc_ID    valid
    tbl[0]  = '{1'b0,1'b1,1'b0,1'b0,16'h0000,0, 1'b1,16'h0000,16'h0000,16'h0000,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,16'h0000,0, 1'b1,16'h0002,16'h1000,16'h0000,1'b1};
    tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,16'h0000,0, 1'b1,16'h0004,16'h1002,16'h0002,1'b1};
    tbl[3]  = '{1'b0,1'b1,1'b0,1'b0,16'h0000,0, 1'b1,16'h0006,16'h1004,16'h0004,1'b1};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,0, 1'b1,16'h0008,16'h1006,16'h0006,1'b1};
    tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,0, 1'b0,16'h000A,16'h1006,16'h0006,1'b1};
    tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,0, 1'b0,16'h000A,16'h1006,16'h0006,1'b1};
    tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,16'h0000,0, 1'b0,16'h000A,16'h1006,16'h0006,1'b1};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b0,16'h0040,1, 1'b1,16'h000A,16'h1008,16'h0008,1'b1};
    tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,16'h0000,1, 1'b1,16'h000A,16'h0000,16'h0008,1'b0};
    tbl[10] = '{1'b0,1'b1,1'b0,1'b0,16'h0000,0, 1'b1,16'h0040,16'h0000,16'h0008,1'b0};
    tbl[11] = '{1'b0,1'b1,1'b0,1'b0,16'h0000,1, 1'b1,16'h0042,16'h1040,16'h0040,1'b1};
    tbl[12] = '{1'b0,1'b1,1'b0,1'b0,16'h0000,1, 1'b1,16'h0042,16'h0000,16'h0040,1'b0};
    tbl[13] = '{1'b0,1'b1,1'b0,1'b0,16'h0000,1, 1'b1,16'h0044,16'h1042,16'h0042,1'b1};
    tbl[14] = '{1'b0,1'b1,1'b0,1'b0,16'h0000,1, 1'b1,16'h0044,16'h0000,16'h0042,1'b0};
    tbl[15] = '{1'b0,1'b1,1'b1,1'b0,16'h0080,0, 1'b1,16'h0046,16'h1044,16'h0044,1'b1};
    tbl[16] = '{1'b0,1'b1,1'b0,1'b0,16'h0000,0, 1'b1,16'h0080,16'h0000,16'h0044,1'b0};
    tbl[17] = '{1'b0,1'b1,1'b0,1'b1,16'h0000,1, 1'b1,16'h0082,16'h1080,16'h0080,1'b1};
    tbl[18] = '{1'b0,1'b1,1'b1,1'b0,16'h0100,1, 1'b1,16'h0082,16'h0000,16'h0080,1'b0};
    tbl[19] = '{1'b0,1'b1,1'b1,1'b0,16'h0100,0, 1'b0,16'h0082,16'h0000,16'h0080,1'b0};
    tbl[20] = '{1'b0,1'b0,1'b0,1'b0,16'h0000,0, 1'b0,16'h0082,16'h0000,16'h0080,1'b0};
    tbl[21] = '{1'b1,1'b1,1'b0,1'b0,16'h0000,0, 1'b0,16'h0082,16'h0000,16'h0080,1'b0};
    tbl[22] = '{1'b0,1'b1,1'b0,1'b0,16'h0000,0, 1'b1,16'h0000,16'h0000,16'h0000,1'b0};
    tbl[23] = '{1'b0,1'b1,1'b0,1'b0,16'h0000,0, 1'b1,16'h0002,16'h1000,16'h0000,1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {15'd0, bus.imem_req}, 16'h0000);
    chk("rst_instr", instruction_ID, 16'h0000);
    chk("rst_pcid", pc_ID, 16'h0000);
    chk("rst_valid", {15'd0, valid_ID}, 16'h0000);
    chk("rst_req_wrap", {15'd0, bus2.imem_req}, 16'h0000);

    // Directed table: stream, stall/HOLD, wait bubbles, FLUSH, branch penalty, halt, restart
    for (int k = 0; k < 24; k++) begin
      rst           = tbl[k].rst;
      pc_enable     = tbl[k].pe;
      branch_taken  = tbl[k].br;
      branch_target = tbl[k].tgt;
      halt          = tbl[k].hlt;
      lat           = tbl[k].lat;
      #1;
      chk($sformatf("t%0d_req", k), {15'd0, bus.imem_req}, {15'd0, tbl[k].req});
      chk($sformatf("t%0d_addr", k), bus.imem_addr, tbl[k].addr);
      chk($sformatf("t%0d_instr", k), instruction_ID, tbl[k].instr);
      chk($sformatf("t%0d_pcid", k), pc_ID, tbl[k].pcid);
      chk($sformatf("t%0d_valid", k), {15'd0, valid_ID}, {15'd0, tbl[k].valid});
      if (k < 3) chk($sformatf("wrap_addr%0d", k), bus2.imem_addr, 16'hFFFE + 16'(2 * k));
      if (k == 1) chk("wrap_instr", instr2, 16'h0FFE);
      if (k == 2) chk("wrap_pcid", pcid2, 16'h0000);
      @(negedge clk);
    end

    // Reset while a request is outstanding: the old request must be abandoned
    halt = 1'b0; branch_taken = 1'b0; pc_enable = 1'b1; lat = 2;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_req", {15'd0, bus.imem_req}, 16'h0000);
    @(negedge clk);
    rst = 1'b0; lat = 0;
    #1;
    chk("midrst_addr", bus.imem_addr, 16'h0000);
    chk("midrst_req1", {15'd0, bus.imem_req}, 16'h0001);
    @(negedge clk);
    #1;
    chk("midrst_instr", instruction_ID, 16'h1000);
    chk("midrst_pcid", pc_ID, 16'h0000);

    // Randomized run against program-order reference
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; pc_enable = 1'b1; branch_taken = 1'b0; lat = 0;
    exp_next = 16'h0000;
    loads = 0;
    #1;
    for (int k = 0; k < 800; k++) begin
      s_pe = pc_enable; s_br = branch_taken; s_tgt = branch_target;
      s_ack = bus.imem_ack; s_req = bus.imem_req; s_addr = bus.imem_addr;
      s_instr = instruction_ID; s_pcid = pc_ID; s_valid = valid_ID;
      @(negedge clk);
      #1;
      if (s_br) begin
        chk("br_bubble_valid", {15'd0, valid_ID}, 16'h0000);
        chk("br_bubble_instr", instruction_ID, 16'h0000);
        chk("br_bubble_pcid", pc_ID, s_pcid);
        exp_next = s_tgt;
      end else if (!s_pe) begin
        chk("stall_instr", instruction_ID, s_instr);
        chk("stall_pcid", pc_ID, s_pcid);
        chk("stall_valid", {15'd0, valid_ID}, {15'd0, s_valid});
      end else if (valid_ID) begin
        chk("seq_pcid", pc_ID, exp_next);
        chk("seq_instr", instruction_ID, exp_next + 16'h1000);
        exp_next = exp_next + 16'd2;
        loads++;
      end else begin
        chk("bubble_instr", instruction_ID, 16'h0000);
        chk("bubble_pcid", pc_ID, s_pcid);
      end
      if (s_req && !s_ack) begin
        chk("req_stable", {15'd0, bus.imem_req}, 16'h0001);
        chk("addr_stable", bus.imem_addr, s_addr);
      end
      pc_enable     = ($urandom_range(0, 3) != 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      branch_target = 16'($urandom) & 16'hFFFE;
      lat           = $urandom_range(0, 2);
      #1;
    end
    chk("progress", {15'd0, (loads > 60)}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined datapath. It owns the PC and issues requests to instruction memory over a req/ack handshake. It presents `instruction_ID`/`pc_ID`/`valid_ID` to the decode stage, where `hazard_detect` compares `instruction_ID` against `instruction_EX`. It obeys `hazard_detect`'s `pc_enable`/`halt` and the EX-stage branch redirect.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP`, 16'h0000, encoding driven on `instruction_ID` for bubbles.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_enable`  in  1  from `hazard_detect`. 1 = decode consumes IF/ID this cycle; 0 = stall, hold IF/ID.
- `halt`  in  1  from `hazard_detect`. 1 = stop fetching permanently until reset.
- `branch_taken`  in  1  EX-stage redirect strobe.
- `branch_target`  in  16  redirect address, valid with `branch_taken`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  16  fetch address; equals PC.
- `imem_ack`  in  1  one-cycle pulse; `imem_rdata` is valid in that cycle.
- `imem_rdata`  in  16  fetched instruction.
- `instruction_ID`  out  16  IF/ID instruction register.
- `pc_ID`  out  16  address of `instruction_ID`.
- `valid_ID`  out  1  1 = `instruction_ID` is a real instruction; 0 = bubble.

## Operation
- Registers: `pc`, `state`, and a hold buffer (`buf_instr`, `buf_pc`). `redirect_pc` is used for FLUSH.
- States:
  - FETCH: `imem_req`=1.
  - HOLD: word buffered; `imem_req`=0.
  - FLUSH: an old request is outstanding and its result will be discarded.
  - DRAIN: the halt is waiting for the outstanding ack.
  - HALTED.
- `imem_req` = (state is FETCH, FLUSH or DRAIN). `imem_addr` = `pc`. Address and req stay stable until ack.
- Priority: rst > branch_taken > halt > pc_enable. In DRAIN and HALTED, `branch_taken` is ignored.
- PC arithmetic: a word is accepted on ack in FETCH. On acceptance, `pc <= pc + 2` (16-bit, 16'hFFFE wraps to 16'h0000).
- FETCH transitions:
  - ack with no branch/halt and `pc_enable`=1: IF/ID <= {rdata, pc, valid=1}; stay in FETCH.
  - ack with `pc_enable`=0: buffer <= {rdata, pc}; go to HOLD; IF/ID holds.
  - branch with ack: discard rdata; `pc <= branch_target`; stay in FETCH.
  - branch without ack: `redirect_pc <= branch_target`; go to FLUSH.
  - halt with ack: discard rdata; go to HALTED.
  - halt without ack: go to DRAIN.
- HOLD transitions:
  - `pc_enable`=1: IF/ID <= buffer with valid=1; go to FETCH.
  - branch: discard buffer; `pc <= branch_target`; go to FETCH.
  - halt: discard buffer; go to HALTED.
- FLUSH transitions:
  - a further branch overwrites `redirect_pc` (latest wins).
  - on ack: discard rdata; `pc <= redirect_pc` (or `branch_target` if a branch arrives in the same cycle); go to FETCH.
  - halt: go to DRAIN.
- DRAIN: on ack, discard rdata and go to HALTED. `pc` is not incremented.
- HALTED: only `rst` leaves this state.
- IF/ID register rules:
  - `branch_taken` accepted: bubble, i.e. `instruction_ID`=NOP, `valid_ID`=0, `pc_ID` unchanged.
  - `pc_enable`=1 with no word available (no ack in FETCH, or state FLUSH/DRAIN/HALTED, or halt asserted): bubble.
  - `pc_enable`=0: hold all three outputs.

## Timing
- Reset values: `pc`=RESET_PC, state=FETCH, `instruction_ID`=NOP, `pc_ID`=16'h0000, `valid_ID`=0, buffer cleared.
- During reset, `imem_req`=0. It is asserted in the first cycle after `rst` falls.
- Latency: with ack in the same cycle as req, the word appears on `instruction_ID` one edge later.
- Throughput: 1 instruction per cycle with zero-wait memory.
- Each memory wait cycle in FETCH costs one bubble when `pc_enable`=1.
- Branch penalty with zero-wait memory: one bubble cycle. The target word enters IF/ID two edges after `branch_taken`.
- Reset mid-request: the outstanding request is abandoned. Any ack arriving in the cycle after `rst` deasserts is treated as the response to the new RESET_PC request; the memory model must not ack abandoned requests.

## Test plan
- Reset, then zero-wait memory returning `addr+16'h1000`: `imem_addr` reads 0,2,4. `instruction_ID` reads 1000,1002,1004 on consecutive cycles; `pc_ID` reads 0,2,4; `valid_ID`=1.
- `pc_enable`=0 for 3 cycles while instruction at 0x0006 is in ID: IF/ID holds 0x1006. The word for 0x0008 is buffered (HOLD, `imem_req`=0). On release, 0x1008 loads next edge with no lost or duplicated word.
- Two-cycle memory latency with `pc_enable`=1: each valid instruction is followed by one bubble (`valid_ID`=0, `instruction_ID`=NOP).
- `branch_taken` with target 0x0040 while a request for 0x000A is unacked: state goes to FLUSH. The ack for 0x000A is discarded and never reaches ID. Next request is 0x0040; `instruction_ID`=0x1040 follows.
- `halt` asserted during an outstanding request: DRAIN until ack, then HALTED. `imem_req`=0 thereafter, `valid_ID`=0, `branch_taken` ignored. `rst` restarts fetch at RESET_PC.
- PC wrap: RESET_PC=16'hFFFE gives `imem_addr` sequence FFFE, 0000, 0002.
